// File: rtl/kf8259_cpu_pkg.sv
// kf8259_cpu_pkg: shared types and constants for the CPU-side interrupt acknowledge block
package kf8259_cpu_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, GAP, HOLD} state_t;
    localparam logic [7:0] CALL_OPCODE_DEFAULT = 8'hCD;
    localparam int INTA_PULSES_8086 = 2;
    localparam int INTA_PULSES_8080 = 3;
endpackage

// File: rtl/kf8259_cpu_interrupt_acknowledge.sv
// kf8259_cpu_interrupt_acknowledge: drives the INTA_n pulse train for an 8259A and returns the captured vector/CALL address
module kf8259_cpu_interrupt_acknowledge
    import kf8259_cpu_pkg::*;
#(
    parameter int INTA_PULSE_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 1,
    parameter logic [7:0] CALL_OPCODE = CALL_OPCODE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_enable,
    input  logic        mode_8086,
    input  logic        interrupt_to_cpu,
    output logic        interrupt_acknowledge_n,
    input  logic [7:0]  data_bus_in,
    output logic        busy,
    output logic        interrupt_taken,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [7:0]  vector,
    output logic [15:0] call_address,
    output logic        opcode_error
);
    localparam int CW = $clog2(INTA_PULSE_CYCLES > INTA_GAP_CYCLES ? INTA_PULSE_CYCLES : INTA_GAP_CYCLES) + 1;

    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic mode_latched;
    logic [7:0] captured [2];
    logic last;

    assign last = idx == (mode_latched ? 2'(INTA_PULSES_8086 - 1) : 2'(INTA_PULSES_8080 - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            mode_latched <= 1'b1;
            captured[0] <= '0;
            captured[1] <= '0;
            interrupt_acknowledge_n <= 1'b1;
            busy <= 1'b0;
            interrupt_taken <= 1'b0;
            result_valid <= 1'b0;
            vector <= '0;
            call_address <= '0;
            opcode_error <= 1'b0;
        end else begin
            interrupt_taken <= 1'b0;
            case (state)
                IDLE: if (interrupt_to_cpu && interrupt_enable) begin
                    state <= PULSE;
                    cnt <= '0;
                    idx <= '0;
                    mode_latched <= mode_8086;
                    interrupt_acknowledge_n <= 1'b0;
                    interrupt_taken <= 1'b1;
                    busy <= 1'b1;
                end
                PULSE: if (cnt == CW'(INTA_PULSE_CYCLES - 1)) begin
                    cnt <= '0;
                    interrupt_acknowledge_n <= 1'b1;
                    if (last) begin
                        state <= HOLD;
                        result_valid <= 1'b1;
                        // the final byte is used straight off the bus on the edge that ends the last pulse
                        if (mode_latched) begin
                            vector <= data_bus_in;
                            opcode_error <= 1'b0;
                        end else begin
                            call_address <= {data_bus_in, captured[1]};
                            opcode_error <= captured[0] != CALL_OPCODE;
                        end
                    end else begin
                        state <= GAP;
                        captured[idx[0]] <= data_bus_in;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                GAP: if (cnt == CW'(INTA_GAP_CYCLES - 1)) begin
                    state <= PULSE;
                    cnt <= '0;
                    idx <= idx + 2'd1;
                    interrupt_acknowledge_n <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                HOLD: if (result_ready) begin
                    state <= IDLE;
                    result_valid <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/kf8259_cpu_interrupt_acknowledge.md
Name: kf8259_cpu_interrupt_acknowledge

Overview:
- CPU-side counterpart of the 8259A control logic.
- Watches INT from the PIC and, when interrupts are enabled, drives the INTA_n pulse train: two pulses in 8086 mode, three in 8080 mode.
- Captures the bytes the PIC places on the data bus and presents them to the CPU core model as a vector or CALL address, with a valid/ready handshake.
- Used as the bus-functional CPU end in system benches, and as the interrupt front end of a soft CPU.

Parameters:
- INTA_PULSE_CYCLES, 2, clock cycles INTA_n is held low per pulse (>=1).
- INTA_GAP_CYCLES, 1, clock cycles INTA_n is held high between pulses (>=1).
- CALL_OPCODE, 8'hCD, expected first byte in 8080 mode.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- interrupt_enable  in  1  CPU IF flag; a sequence starts only when this is 1.
- mode_8086  in  1  1 = 8086 (2 pulses), 0 = 8080 (3 pulses); sampled at sequence start.
- interrupt_to_cpu  in  1  INT from the PIC, level.
- interrupt_acknowledge_n  out  1  INTA_n to the PIC.
- data_bus_in  in  8  PIC data bus, valid while INTA_n is low.
- busy  out  1  sequence in progress or result pending.
- interrupt_taken  out  1  one-cycle pulse when a sequence starts.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- vector  out  8  8086 vector byte (second pulse).
- call_address  out  16  8080 address {third byte, second byte}.
- opcode_error  out  1  8080 first byte != CALL_OPCODE; qualified by result_valid.

Behaviour:
- Reset values: interrupt_acknowledge_n=1, busy=0, interrupt_taken=0, result_valid=0, vector=0, call_address=0, opcode_error=0.
- Reset asserted mid-pulse forces INTA_n to 1 at the next edge. Partial captures are discarded.
- States:
  - IDLE
  - PULSE (counter cnt, pulse index idx)
  - GAP
  - HOLD
- All outputs are registered.
- IDLE: if interrupt_to_cpu && interrupt_enable at edge k:
  - Next state PULSE, idx=0, cnt=0.
  - Latch mode_8086 into mode_latched.
  - After edge k: INTA_n=0, interrupt_taken=1 for one cycle, busy=1.
- PULSE: INTA_n=0 for exactly INTA_PULSE_CYCLES cycles. On the edge that ends the pulse:
  - Capture data_bus_in into byte[idx].
  - INTA_n returns to 1.
  - If idx is the last pulse (1 for 8086, 2 for 8080), go to HOLD. Otherwise go to GAP.
- GAP: INTA_n=1 for INTA_GAP_CYCLES cycles, then PULSE with idx+1.
- Results, with 8086 timing as the reference case:
  - Second pulse ends at edge k+2P+G.
  - result_valid=1 and vector=byte[1] from that same edge.
  - byte[0] is ignored in 8086 mode.
- 8080 results:
  - call_address = {byte[2], byte[1]}.
  - opcode_error = (byte[0] != CALL_OPCODE).
  - result_valid rises at edge k+3P+2G.
- HOLD:
  - result_valid stays 1 and result fields stay stable until a cycle with result_ready=1.
  - At that edge: result_valid=0, busy=0, return to IDLE. A new request can be taken from the following edge.
  - result_ready while not valid has no effect.
- Mid-sequence changes:
  - INT deasserted during PULSE/GAP: the sequence continues to completion (the PIC returns the spurious IR7 vector).
  - interrupt_enable or mode_8086 changing mid-sequence: ignored.
- INT held high in HOLD: no new INTA until the handshake completes.
- Counters are $clog2(max(P,G))+1 bits wide and saturate-free: they are reset on every state entry.

Decomposition:
- Package kf8259_cpu_pkg:
  - state enum (IDLE, PULSE, GAP, HOLD)
  - constant CALL_OPCODE_DEFAULT=8'hCD
  - pulse-count constants INTA_PULSES_8086=2, INTA_PULSES_8080=3
- No sub-module. An optional kf8259_pulse_timer (cycle counter with done) may be factored out, but a single module is preferred.

Test Plan:
- 8086, P=2, G=1: INT=1, IF=1, bus=8'hFF on pulse 1 and 8'h4B on pulse 2 -> INTA_n low 2 cycles, high 1 cycle, low 2 cycles; vector=8'h4B; result_valid 5 cycles after start; interrupt_taken pulses once.
- 8080: bus CD/34/12 -> three pulses; call_address=16'h1234, opcode_error=0. Same sequence with first byte 8'h00 -> opcode_error=1.
- IF=0 with INT=1 for 10 cycles -> INTA_n stays 1 and busy=0. Raise IF -> sequence starts next edge.
- result_ready held 0 for 8 cycles with INT still high -> result_valid and vector stable, no extra INTA. result_ready=1 -> valid drops; new sequence starts the next cycle.
- INT dropped after pulse 1 -> second pulse still issued; vector captures the bus value (8'h4F).
- reset asserted during pulse 2 -> INTA_n=1, busy=0, result_valid=0 after that edge; no result produced.
